// File: rtl/data_mem_fetch.sv
// Read engine: pulls a programmed number of 128-bit blocks from the data memory
// read port and streams them to the cipher core through a small output FIFO.
module data_mem_fetch #(
    parameter int unsigned DATA_W        = 128,
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned BUF_DEPTH     = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic              abort,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        mem_ptr_diff,
    output logic              mem_read_flag,
    output logic              mem_incr_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  fetched
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW:0]   FULL_FILL   = (PW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  blk_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [DATA_W-1:0] buf_q [BUF_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       fill;
    logic              full, empty, capture, push, pop, settle_last, last_blk;

    assign full        = (fill == FULL_FILL);
    assign empty       = (fill == '0);
    assign out_valid   = !empty;
    assign out_data    = buf_q[rd_ptr];
    assign push        = capture;
    assign pop         = out_valid && out_ready;
    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign last_blk    = ((fetched + CNT_W'(1)) == blk_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = (num_blocks == '0) ? DRAIN : SETTLE;
            SETTLE:  if (settle_last) state_nxt = SAMPLE;
            SAMPLE:  if (capture) state_nxt = last_blk ? DRAIN : SETTLE;
            DRAIN:   if (empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Capture needs a slot free before this cycle's pop; abort suppresses the pointer advance.
    always_comb begin
        capture       = (state == SAMPLE) && (mem_ptr_diff == 2'd2) && !full && !abort;
        mem_incr_read = capture;
        mem_read_flag = (state == SETTLE) || (state == SAMPLE);
        busy          = (state != IDLE);
        done          = (state == DRAIN) && empty && !abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt    <= '0;
            fetched    <= '0;
            settle_cnt <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else if (abort) begin
            fetched    <= '0;
            settle_cnt <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
        end else begin
            if (state == IDLE && start) begin
                blk_cnt <= num_blocks;
                fetched <= '0;
            end
            if (state == SETTLE) settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
            if (capture) fetched <= fetched + CNT_W'(1);
            if (push) begin
                buf_q[wr_ptr] <= mem_data;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (PW+1)'(1);
                2'b01:   fill <= fill - (PW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule
